// File: rtl/mem_access_if.sv
// Data-bus bundle between the memory-access stage (master) and the data memory port (slave).
// The master issues one request at a time and waits for addr_ok and then data_ok.
interface mem_access_if;
  logic        data_req;
  logic        data_we;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on the data bus, aligns/extends load data,
// flags misaligned addresses, and stalls ex_mem while a bus transaction is outstanding.
module mem_access #(
  parameter int ALE_BIT = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        ex_valid,
  input  logic [4:0]  ex_wd,
  input  logic        ex_wreg,
  input  logic [31:0] ex_wdata,
  input  logic [31:0] ex_store_data,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_inst_pc,
  input  logic [31:0] ex_instr,
  input  logic        ex_excp,
  input  logic [15:0] ex_excp_num,
  mem_access_if.master bus,
  output logic        stall_req,
  output logic [4:0]  mem_wd,
  output logic        mem_wreg,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_inst_pc,
  output logic [31:0] mem_instr,
  output logic        mem_inst_valid,
  output logic        excp_o,
  output logic [15:0] excp_num_o
);

  localparam logic [3:0] OP_LDB  = 4'd1;
  localparam logic [3:0] OP_LDBU = 4'd2;
  localparam logic [3:0] OP_LDH  = 4'd3;
  localparam logic [3:0] OP_LDHU = 4'd4;
  localparam logic [3:0] OP_LDW  = 4'd5;
  localparam logic [3:0] OP_STB  = 4'd6;
  localparam logic [3:0] OP_STH  = 4'd7;
  localparam logic [3:0] OP_STW  = 4'd8;
  localparam logic [15:0] ALE_MASK = 16'(32'd1 << ALE_BIT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_t;
  state_t state_reg;

  logic [3:0]  op_reg;
  logic [31:0] addr_reg;
  logic [4:0]  wd_reg;
  logic        wreg_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;

  logic        is_load, is_store, is_half, is_word, ale, exc_any, issue;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] resp_wdata;

  assign is_load  = (ex_mem_op >= OP_LDB) && (ex_mem_op <= OP_LDW);
  assign is_store = (ex_mem_op >= OP_STB) && (ex_mem_op <= OP_STW);
  assign is_half  = (ex_mem_op == OP_LDH) || (ex_mem_op == OP_LDHU) || (ex_mem_op == OP_STH);
  assign is_word  = (ex_mem_op == OP_LDW) || (ex_mem_op == OP_STW);
  assign ale      = (is_half && ex_wdata[0]) || (is_word && (ex_wdata[1:0] != 2'b00));
  assign exc_any  = ex_excp || ale;
  assign issue    = ex_valid && (is_load || is_store) && !exc_any;

  always_comb begin
    st_wstrb = 4'b0000;
    st_wdata = ex_store_data;
    case (ex_mem_op)
      OP_STB: begin
        st_wstrb = 4'b0001 << ex_wdata[1:0];
        st_wdata = {4{ex_store_data[7:0]}};
      end
      OP_STH: begin
        st_wstrb = ex_wdata[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{ex_store_data[15:0]}};
      end
      OP_STW:  st_wstrb = 4'b1111;
      default: ;
    endcase
  end

  // Lane selection uses the latched byte address; the bus only sees the word address.
  always_comb begin
    case (addr_reg[1:0])
      2'd0:    ld_byte = bus.data_rdata[7:0];
      2'd1:    ld_byte = bus.data_rdata[15:8];
      2'd2:    ld_byte = bus.data_rdata[23:16];
      default: ld_byte = bus.data_rdata[31:24];
    endcase
    ld_half = addr_reg[1] ? bus.data_rdata[31:16] : bus.data_rdata[15:0];
    case (op_reg)
      OP_LDB:  load_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LDBU: load_data = {24'd0, ld_byte};
      OP_LDH:  load_data = {{16{ld_half[15]}}, ld_half};
      OP_LDHU: load_data = {16'd0, ld_half};
      default: load_data = bus.data_rdata;
    endcase
    resp_wdata = bus.data_we ? addr_reg : load_data;
  end

  // Gated by rst so the hold request also drops the instant reset asserts.
  always_comb begin
    stall_req = 1'b0;
    case (state_reg)
      S_IDLE:  stall_req = issue;
      S_REQ:   stall_req = 1'b1;
      S_WAIT:  stall_req = !bus.data_data_ok;
      S_DRAIN: stall_req = 1'b1;
      default: stall_req = 1'b0;
    endcase
    if (!rst)
      stall_req = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      bus.data_req   <= 1'b0;
      bus.data_we    <= 1'b0;
      bus.data_wstrb <= 4'b0000;
      bus.data_addr  <= 32'd0;
      bus.data_wdata <= 32'd0;
      op_reg         <= 4'd0;
      addr_reg       <= 32'd0;
      wd_reg         <= 5'd0;
      wreg_reg       <= 1'b0;
      pc_reg         <= 32'd0;
      instr_reg      <= 32'd0;
      mem_wd         <= 5'd0;
      mem_wreg       <= 1'b0;
      mem_wdata      <= 32'd0;
      mem_inst_pc    <= 32'd0;
      mem_instr      <= 32'd0;
      mem_inst_valid <= 1'b1;
      excp_o         <= 1'b0;
      excp_num_o     <= 16'd0;
    end else begin
      mem_wd         <= 5'd0;
      mem_wreg       <= 1'b0;
      mem_wdata      <= 32'd0;
      mem_inst_pc    <= 32'd0;
      mem_instr      <= 32'd0;
      mem_inst_valid <= 1'b1;
      excp_o         <= 1'b0;
      excp_num_o     <= 16'd0;
      if (flush) begin
        bus.data_req <= 1'b0;
        case (state_reg)
          S_REQ:   state_reg <= bus.data_addr_ok ? S_DRAIN : S_IDLE;
          S_WAIT:  state_reg <= bus.data_data_ok ? S_IDLE : S_DRAIN;
          S_DRAIN: state_reg <= bus.data_data_ok ? S_IDLE : S_DRAIN;
          default: state_reg <= S_IDLE;
        endcase
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (issue) begin
              state_reg      <= S_REQ;
              bus.data_req   <= 1'b1;
              bus.data_we    <= is_store;
              bus.data_wstrb <= st_wstrb;
              bus.data_addr  <= {ex_wdata[31:2], 2'b00};
              bus.data_wdata <= st_wdata;
              op_reg         <= ex_mem_op;
              addr_reg       <= ex_wdata;
              wd_reg         <= ex_wd;
              wreg_reg       <= ex_wreg;
              pc_reg         <= ex_inst_pc;
              instr_reg      <= ex_instr;
            end else if (ex_valid) begin
              mem_wd         <= ex_wd;
              mem_wreg       <= ex_wreg && !exc_any;
              mem_wdata      <= ex_wdata;
              mem_inst_pc    <= ex_inst_pc;
              mem_instr      <= ex_instr;
              mem_inst_valid <= 1'b0;
              excp_o         <= exc_any;
              excp_num_o     <= ex_excp_num | (ale ? ALE_MASK : 16'd0);
            end
          end
          S_REQ: begin
            if (bus.data_addr_ok) begin
              state_reg    <= S_WAIT;
              bus.data_req <= 1'b0;
            end
          end
          S_WAIT: begin
            if (bus.data_data_ok) begin
              state_reg      <= S_IDLE;
              mem_wd         <= wd_reg;
              mem_wreg       <= bus.data_we ? 1'b0 : wreg_reg;
              mem_wdata      <= resp_wdata;
              mem_inst_pc    <= pc_reg;
              mem_instr      <= instr_reg;
              mem_inst_valid <= 1'b0;
            end
          end
          S_DRAIN: begin
            if (bus.data_data_ok)
              state_reg <= S_IDLE;
          end
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed + randomized bench for mem_access: a bus responder with random handshake delays,
// and an arithmetic reference model for alignment, extension, strobes and exceptions.
`timescale 1ns/1ps
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        ex_valid = 1'b0;
  logic [4:0]  ex_wd = 5'd0;
  logic        ex_wreg = 1'b0;
  logic [31:0] ex_wdata = 32'd0;
  logic [31:0] ex_store_data = 32'd0;
  logic [3:0]  ex_mem_op = 4'd0;
  logic [31:0] ex_inst_pc = 32'd0;
  logic [31:0] ex_instr = 32'd0;
  logic        ex_excp = 1'b0;
  logic [15:0] ex_excp_num = 16'd0;
  logic        stall_req;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic [31:0] mem_inst_pc;
  logic [31:0] mem_instr;
  logic        mem_inst_valid;
  logic        excp_o;
  logic [15:0] excp_num_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_access_if bus();

  mem_access #(.ALE_BIT(9)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op), .ex_inst_pc(ex_inst_pc),
    .ex_instr(ex_instr), .ex_excp(ex_excp), .ex_excp_num(ex_excp_num),
    .bus(bus), .stall_req(stall_req),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_inst_pc(mem_inst_pc), .mem_instr(mem_instr), .mem_inst_valid(mem_inst_valid),
    .excp_o(excp_o), .excp_num_o(excp_num_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ale_of(input logic [3:0] op, input logic [31:0] a);
    return ((op == 4'd3 || op == 4'd4 || op == 4'd7) && (a % 2 != 0)) ||
           ((op == 4'd5 || op == 4'd8) && (a % 4 != 0));
  endfunction

  function automatic logic [31:0] load_model(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (op)
      4'd1:    return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      4'd2:    return b;
      4'd3:    return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      4'd4:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [31:0] strb_model(input logic [3:0] op, input logic [31:0] a);
    case (op)
      4'd6:    return 32'd1 << (a % 4);
      4'd7:    return 32'd3 << (2 * ((a / 2) % 2));
      4'd8:    return 32'hF;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] sdata_model(input logic [3:0] op, input logic [31:0] sd);
    case (op)
      4'd6:    return (sd & 32'hFF) * 32'h0101_0101;
      4'd7:    return (sd & 32'hFFFF) * 32'h0001_0001;
      default: return sd;
    endcase
  endfunction

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after the result edge.
  task automatic do_mem(input logic [3:0] op, input logic [31:0] a, input logic [31:0] sd,
                        input logic [31:0] rd, input int ao_d, input int do_d);
    logic [4:0]  wd;
    logic        wr;
    logic [31:0] pc, ins;
    logic        st;
    int req_cnt, wait_cnt, cyc;
    bit acc, done;
    wd = 5'($urandom); wr = 1'($urandom); pc = $urandom; ins = $urandom;
    st = (op >= 4'd6);
    req_cnt = 0; wait_cnt = 0; cyc = 0; acc = 0; done = 0;
    ex_valid = 1'b1; ex_mem_op = op; ex_wdata = a; ex_store_data = sd; ex_wd = wd;
    ex_wreg = wr; ex_inst_pc = pc; ex_instr = ins; ex_excp = 1'b0; ex_excp_num = 16'($urandom);
    while (!done) begin
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
      if (!acc) begin
        if (bus.data_req) begin
          if (req_cnt == ao_d) begin
            bus.data_addr_ok = 1'b1; acc = 1; wait_cnt = 1;
            check("bus_addr", bus.data_addr, a & 32'hFFFF_FFFC);
            check("bus_we", 32'(bus.data_we), 32'(st));
            check("bus_wstrb", 32'(bus.data_wstrb), strb_model(op, a));
            if (st) check("bus_wdata", bus.data_wdata, sdata_model(op, sd));
          end else req_cnt++;
        end
      end else if (wait_cnt == do_d) begin
        bus.data_data_ok = 1'b1; bus.data_rdata = rd; done = 1;
      end else wait_cnt++;
      #4;
      check("stall_busy", 32'(stall_req), 32'(!done));
      if (cyc > 0) check("bubble_busy", 32'(mem_inst_valid), 32'd1);
      @(posedge clk); #1;
      cyc++;
      if (cyc > 40) begin
        check("mem_timeout", 32'd0, 32'd1);
        done = 1;
      end
    end
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; ex_valid = 1'b0;
    check("mem_valid", 32'(mem_inst_valid), 32'd0);
    check("mem_wd", 32'(mem_wd), 32'(wd));
    check("mem_wreg", 32'(mem_wreg), st ? 32'd0 : 32'(wr));
    check("mem_wdata", mem_wdata, st ? a : load_model(op, a, rd));
    check("mem_pc", mem_inst_pc, pc);
    check("mem_instr", mem_instr, ins);
    check("mem_excp", 32'(excp_o), 32'd0);
    $display("mem op=%0d addr=%h rdata=%h -> wdata=%h wreg=%0d", op, a, rd, mem_wdata, mem_wreg);
  endtask

  // Non-memory op, misaligned access, or upstream exception: consumed without a bus request.
  task automatic do_simple(input logic [3:0] op, input logic [31:0] a, input logic excp);
    logic [4:0]  wd;
    logic        wr, al, exc;
    logic [31:0] pc, ins;
    logic [15:0] num;
    wd = 5'($urandom); wr = 1'($urandom); pc = $urandom; ins = $urandom; num = 16'($urandom);
    al = ale_of(op, a); exc = excp | al;
    ex_valid = 1'b1; ex_mem_op = op; ex_wdata = a; ex_store_data = $urandom; ex_wd = wd;
    ex_wreg = wr; ex_inst_pc = pc; ex_instr = ins; ex_excp = excp; ex_excp_num = num;
    #4;
    check("simple_stall", 32'(stall_req), 32'd0);
    check("simple_req", 32'(bus.data_req), 32'd0);
    @(posedge clk); #1;
    check("simple_valid", 32'(mem_inst_valid), 32'd0);
    check("simple_wd", 32'(mem_wd), 32'(wd));
    check("simple_wreg", 32'(mem_wreg), exc ? 32'd0 : 32'(wr));
    check("simple_wdata", mem_wdata, a);
    check("simple_pc", mem_inst_pc, pc);
    check("simple_instr", mem_instr, ins);
    check("simple_excp", 32'(excp_o), 32'(exc));
    check("simple_num", 32'(excp_num_o), 32'(num) | (al ? 32'h200 : 32'h0));
    check("simple_noreq", 32'(bus.data_req), 32'd0);
    ex_valid = 1'b0;
    $display("simple op=%0d addr=%h excp=%0d ale=%0d -> excp_o=%0d num=%h", op, a, excp, al, excp_o, excp_num_o);
  endtask

  task automatic idle_check();
    ex_valid = 1'b0;
    @(posedge clk); #1;
    check("idle_valid", 32'(mem_inst_valid), 32'd1);
    check("idle_wreg", 32'(mem_wreg), 32'd0);
    check("idle_excp", 32'(excp_o), 32'd0);
    $display("bubble valid=%0d", mem_inst_valid);
  endtask

  initial begin
    logic [3:0]  op;
    logic [31:0] a;
    logic        ex;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;
    ex_valid = 1'b1; ex_mem_op = 4'd5; ex_wdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(mem_inst_valid), 32'd1);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_excp", 32'(excp_o), 32'd0);
    check("rst_num", 32'(excp_num_o), 32'd0);
    check("rst_req", 32'(bus.data_req), 32'd0);
    check("rst_stall", 32'(stall_req), 32'd0);
    $display("reset valid=%0d req=%0d stall=%0d", mem_inst_valid, bus.data_req, stall_req);
    ex_valid = 1'b0;
    #2 rst = 1'b1;
    @(posedge clk); #1;

    do_mem(4'd1, 32'h0000_1003, 32'd0, 32'h80FF_0000, 0, 1);
    do_mem(4'd7, 32'h0000_2002, 32'h0000_1234, 32'd0, 0, 1);
    do_simple(4'd5, 32'h0000_3001, 1'b0);
    for (int i = 0; i < 3; i++) do_simple(4'd0, $urandom, 1'b0);
    idle_check();

    // Flush while waiting for data: the late response must be swallowed.
    ex_valid = 1'b1; ex_mem_op = 4'd5; ex_wdata = 32'h0000_4000; ex_excp = 1'b0;
    @(posedge clk); #1;
    check("fl_req", 32'(bus.data_req), 32'd1);
    bus.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    check("fl_req_drop", 32'(bus.data_req), 32'd0);
    flush = 1'b1;
    #4 check("fl_stall", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("fl_bubble", 32'(mem_inst_valid), 32'd1);
    ex_valid = 1'b1; ex_mem_op = 4'd5; ex_wdata = 32'h0000_5000;
    for (int i = 0; i < 2; i++) begin
      #4;
      check("drain_stall", 32'(stall_req), 32'd1);
      check("drain_noreq", 32'(bus.data_req), 32'd0);
      @(posedge clk); #1;
    end
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hDEAD_BEEF;
    #4 check("drain_ok_stall", 32'(stall_req), 32'd1);
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0;
    check("drain_discard", 32'(mem_inst_valid), 32'd1);
    check("drain_noreq2", 32'(bus.data_req), 32'd0);
    $display("flush/drain done valid=%0d", mem_inst_valid);
    do_mem(4'd5, 32'h0000_5000, 32'd0, 32'hCAFE_F00D, 1, 2);

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      ex = ($urandom_range(0, 7) == 0);
      if (op >= 4'd1 && op <= 4'd8 && !ex && !ale_of(op, a))
        do_mem(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
      else
        do_simple(op, a, ex);
      if ($urandom_range(0, 3) == 0) idle_check();
    end

    // Asynchronous reset while a result is on the outputs.
    do_simple(4'd0, 32'h1111_2222, 1'b0);
    rst = 1'b0;
    #1;
    check("arst_valid", 32'(mem_inst_valid), 32'd1);
    check("arst_wdata", mem_wdata, 32'd0);
    check("arst_wd", 32'(mem_wd), 32'd0);
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset mid-WAIT; a later data_ok is ignored.
    ex_valid = 1'b1; ex_mem_op = 4'd5; ex_wdata = 32'h0000_6000;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    check("wait_stall", 32'(stall_req), 32'd1);
    rst = 1'b0;
    #1;
    check("wrst_stall", 32'(stall_req), 32'd0);
    check("wrst_req", 32'(bus.data_req), 32'd0);
    check("wrst_valid", 32'(mem_inst_valid), 32'd1);
    ex_valid = 1'b0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'h1234_5678;
    #4 check("post_rst_stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0;
    check("post_rst_valid", 32'(mem_inst_valid), 32'd1);
    check("post_rst_req", 32'(bus.data_req), 32'd0);
    $display("reset mid-wait valid=%0d", mem_inst_valid);
    do_mem(4'd3, 32'h0000_7002, 32'd0, 32'h8001_7FFF, 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
